// File: rtl/touch_event_queue.sv
// ============================================================================
//  Module   : touch_event_queue
//  Purpose  : Queues one-cycle gesture pulses as 2-bit event codes for a
//             valid/ready consumer, and tracks events lost to a full queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module touch_event_queue #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_touch_key1,
  input  logic                     i_touch_key2,
  input  logic                     i_touch_key3,
  input  logic                     i_evt_ready,
  input  logic                     i_ovf_clr,
  output logic                     o_evt_valid,
  output logic [1:0]               o_evt_code,
  output logic [$clog2(DEPTH):0]   o_evt_count,
  output logic                     o_overflow,
  output logic [DROP_W-1:0]        o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  localparam logic [1:0] c_st_empty   = 2'd0;
  localparam logic [1:0] c_st_partial = 2'd1;
  localparam logic [1:0] c_st_full    = 2'd2;

  logic [1:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_count;
  logic [1:0]        r_state;
  logic [1:0]        r_code;
  logic              r_overflow;
  logic [DROP_W-1:0] r_drop_cnt;

  logic              w_push;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;
  logic [1:0]        w_code;
  logic [AW-1:0]     w_rd_next;
  logic [AW-1:0]     w_wr_next;
  logic [AW:0]       w_count_next;
  logic [1:0]        w_state_next;
  logic [1:0]        w_code_next;

  always_comb begin
    w_push = i_touch_key1 | i_touch_key2 | i_touch_key3;
    if (i_touch_key3)      w_code = 2'b11;
    else if (i_touch_key2) w_code = 2'b10;
    else if (i_touch_key1) w_code = 2'b01;
    else                   w_code = 2'b00;

    w_pop    = (r_state != c_st_empty) && i_evt_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    w_accept = w_push && ((r_count != c_depth) || w_pop);
    w_drop   = w_push && !w_accept;

    w_rd_next = w_pop    ? r_rd_ptr + 1'b1 : r_rd_ptr;
    w_wr_next = w_accept ? r_wr_ptr + 1'b1 : r_wr_ptr;

    case ({w_accept, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase

    if (w_count_next == '0)           w_state_next = c_st_empty;
    else if (w_count_next == c_depth) w_state_next = c_st_full;
    else                              w_state_next = c_st_partial;

    // Registered head: the new entry bypasses memory when it lands at the head slot.
    if (w_count_next == '0)                         w_code_next = 2'b00;
    else if (w_accept && (r_wr_ptr == w_rd_next))   w_code_next = w_code;
    else                                            w_code_next = r_mem[w_rd_next];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 2'b00;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_state  <= c_st_empty;
      r_code   <= 2'b00;
    end else begin
      if (w_accept) r_mem[r_wr_ptr] <= w_code;
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= w_wr_next;
      r_count  <= w_count_next;
      r_state  <= w_state_next;
      r_code   <= w_code_next;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (i_ovf_clr)        r_drop_cnt <= DROP_W'(1);
      else if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign o_evt_valid = (r_state != c_st_empty);
  assign o_evt_code  = r_code;
  assign o_evt_count = r_count;
  assign o_overflow  = r_overflow;
  assign o_drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_touch_event_queue.sv
// ============================================================================
//  Module   : tb_touch_event_queue
//  Purpose  : Self-checking bench for touch_event_queue with a queue scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_touch_event_queue;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;

  logic        clk;
  logic        rst_n;
  logic [2:0]  keys;
  logic        ready;
  logic        clr;
  logic        evt_valid;
  logic [1:0]  evt_code;
  logic [2:0]  evt_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int          checks;
  int          errors;
  logic [1:0]  mq[$];
  logic        movf;
  int          mdrop;

  touch_event_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_touch_key1 (keys[0]),
    .i_touch_key2 (keys[1]),
    .i_touch_key3 (keys[2]),
    .i_evt_ready  (ready),
    .i_ovf_clr    (clr),
    .o_evt_valid  (evt_valid),
    .o_evt_code   (evt_code),
    .o_evt_count  (evt_count),
    .o_overflow   (overflow),
    .o_drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: apply inputs for one rising edge, update the model, return at next negedge.
  task automatic drive(input logic [2:0] k, input logic r, input logic c);
    logic       pop, push, acc;
    logic [1:0] code;
    keys = k; ready = r; clr = c;
    @(posedge clk);
    pop  = (mq.size() != 0) && r;
    push = |k;
    code = k[2] ? 2'b11 : k[1] ? 2'b10 : k[0] ? 2'b01 : 2'b00;
    acc  = push && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(code);
    if (push && !acc) begin
      movf  = 1'b1;
      mdrop = c ? 1 : ((mdrop == 255) ? 255 : mdrop + 1);
    end else if (c) begin
      movf  = 1'b0;
      mdrop = 0;
    end
    @(negedge clk);
    keys = 3'b000; ready = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    checks++; if (evt_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", evt_code); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    repeat (3) drive(3'b000, 1'b0, 1'b0);
    drive(3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b want 1", i, evt_valid); end
      checks++; if (evt_code !== 2'b10) begin errors++; $display("FAIL single_code[%0d] got %b want 10", i, evt_code); end
      checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL single_count[%0d] got %0d want 1", i, evt_count); end
      drive(3'b000, 1'b0, 1'b0);
    end
    checks++; if (evt_code !== mq[0]) begin errors++; $display("FAIL single_pop_code got %b want %b", evt_code, mq[0]); end
    drive(3'b000, 1'b1, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_after_valid got %b want 0", evt_valid); end
    checks++; if (evt_code !== 2'b00) begin errors++; $display("FAIL single_after_code got %b want 00", evt_code); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL single_after_count got %0d want 0", evt_count); end
  endtask

  task automatic test_order();
    logic [2:0] seq [4];
    seq[0] = 3'b001; seq[1] = 3'b100; seq[2] = 3'b010; seq[3] = 3'b001;
    for (int i = 0; i < 4; i++) drive(seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_count !== 3'(4 - i)) begin errors++; $display("FAIL order_count[%0d] got %0d want %0d", i, evt_count, 4 - i); end
      checks++; if (evt_code !== mq[0]) begin errors++; $display("FAIL order_code[%0d] got %b want %b", i, evt_code, mq[0]); end
      drive(3'b000, 1'b1, 1'b0);
    end
    checks++; if (evt_count !== 3'd0 || evt_valid !== 1'b0) begin errors++; $display("FAIL order_empty got count %0d valid %b want 0 0", evt_count, evt_valid); end
  endtask

  task automatic test_overflow();
    drive(3'b010, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b0);
    drive(3'b010, 1'b0, 1'b0);
    repeat (3) drive(3'b001, 1'b0, 1'b0);
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", evt_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL ovf_drop got %0d want 3", drop_cnt); end
    checks++; if (evt_code !== 2'b10) begin errors++; $display("FAIL ovf_head got %b want 10", evt_code); end
    drive(3'b000, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_flag got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL clr_count got %0d want 4", evt_count); end
  endtask

  task automatic test_full_push_pop();
    drive(3'b100, 1'b1, 1'b0);
    checks++; if (evt_count !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d want 4", evt_count); end
    checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fpp_drop got %0d/%b want 0/0", drop_cnt, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_code !== mq[0]) begin errors++; $display("FAIL fpp_drain[%0d] got %b want %b", i, evt_code, mq[0]); end
      if (i == 3) begin
        checks++; if (evt_code !== 2'b11) begin errors++; $display("FAIL fpp_fourth got %b want 11", evt_code); end
      end
      drive(3'b000, 1'b1, 1'b0);
    end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b want 0", evt_valid); end
  endtask

  task automatic test_multi_key();
    drive(3'b111, 1'b0, 1'b0);
    checks++; if (evt_count !== 3'd1) begin errors++; $display("FAIL multi_count got %0d want 1", evt_count); end
    checks++; if (evt_code !== 2'b11) begin errors++; $display("FAIL multi_code got %b want 11", evt_code); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL multi_drop got %0d want 0", drop_cnt); end
    repeat (3) drive(3'b010, 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clrdrop_flag got %b want 1", overflow); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clrdrop_cnt got %0d want 1", drop_cnt); end
    checks++; if (drop_cnt !== 8'(mdrop)) begin errors++; $display("FAIL clrdrop_model got %0d want %0d", drop_cnt, mdrop); end
    drive(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_code !== mq[0]) begin errors++; $display("FAIL multi_drain[%0d] got %b want %b", i, evt_code, mq[0]); end
      drive(3'b000, 1'b1, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    drive(3'b010, 1'b0, 1'b0);
    drive(3'b100, 1'b0, 1'b0);
    drive(3'b001, 1'b0, 1'b0);
    ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (evt_valid !== 1'b0 || evt_code !== 2'b00) begin errors++; $display("FAIL arst_head got %b/%b want 0/00", evt_valid, evt_code); end
    checks++; if (evt_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", evt_count); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL arst_ovf got %b/%0d want 0/0", overflow, drop_cnt); end
    ready = 1'b0;
    mq.delete(); movf = 1'b0; mdrop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL arst_stale got %b want 0", evt_valid); end
    drive(3'b001, 1'b0, 1'b0);
    checks++; if (evt_count !== 3'd1 || evt_code !== 2'b01) begin errors++; $display("FAIL arst_new got %0d/%b want 1/01", evt_count, evt_code); end
    drive(3'b000, 1'b1, 1'b0);
    checks++; if (evt_valid !== 1'b0 || evt_count !== 3'(mq.size())) begin errors++; $display("FAIL arst_drain got %b/%0d want 0/0", evt_valid, evt_count); end
  endtask

  initial begin
    checks = 0; errors = 0; movf = 1'b0; mdrop = 0;
    rst_n = 1'b0; keys = 3'b000; ready = 1'b0; clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_full_push_pop();
    test_multi_key();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/touch_event_queue.md
# touch_event_queue

Buffers gesture pulses from the touch gesture detector (single tap, double tap, long press) into a small FIFO of 2-bit event codes, presented to the downstream consumer (CPU I/O port or control FSM) through a valid/ready handshake. The block sits directly downstream of the gesture detector in the CLK1K domain. It decouples one-cycle gesture pulses from a consumer that may be slow to read, and it tracks dropped events.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- DROP_W, 8, width of the saturating drop counter
- CLK1K  in  1  1 kHz system clock; all state updates on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- TOUCH_KEY1  in  1  single-tap pulse, one cycle
- TOUCH_KEY2  in  1  double-tap pulse, one cycle
- TOUCH_KEY3  in  1  long-press pulse, one cycle
- EVT_READY  in  1  consumer accepts head entry
- OVF_CLR  in  1  clears OVERFLOW and DROP_CNT
- EVT_VALID  out  1  head entry present
- EVT_CODE  out  2  head entry code: 01 single, 10 double, 11 long; 00 when EVT_VALID=0
- EVT_COUNT  out  log2(DEPTH)+1  number of stored entries
- OVERFLOW  out  1  sticky; an event was dropped
- DROP_CNT  out  DROP_W  dropped-event count, saturating at all-ones

## Operation
- Encode: KEY3 gives 11, else KEY2 gives 10, else KEY1 gives 01.
  - Priority KEY3 > KEY2 > KEY1 applies when more than one key is high in a cycle.
  - Exactly one event is generated per cycle. Lower-priority simultaneous keys are discarded silently and are not counted as drops.
- push = any key high. pop = EVT_VALID && EVT_READY.
- Storage: circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. A separate occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Push accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
  - When full and popping, the freed slot takes the new entry and count stays DEPTH.
- Push rejected when count == DEPTH and there is no pop.
  - Entry is lost and FIFO contents are unchanged.
  - OVERFLOW is set to 1.
  - DROP_CNT increments, saturating at 2^DROP_W-1.
- Simultaneous push and pop with count in 1..DEPTH-1: both occur and count is unchanged.
- Push with count 0 and no pop: entry stored and count becomes 1.
- Pop with count 0 is impossible because EVT_VALID=0.
- OVF_CLR=1 clears OVERFLOW and DROP_CNT to 0.
  - If a rejected push occurs in the same cycle, the rejected push wins: OVERFLOW becomes 1 and DROP_CNT becomes 1.
- Internal FSM for output status, states EMPTY, PARTIAL, FULL, derived from the next count:
  - EMPTY to PARTIAL on a push without a pop.
  - PARTIAL to FULL when count reaches DEPTH.
  - FULL to PARTIAL on a pop without an accepted push.
  - PARTIAL to EMPTY when count reaches 0.
- Reset (RSTN=0, any time including mid-handshake):
  - Pointers, count and FIFO contents clear; state becomes EMPTY.
  - EVT_VALID=0, EVT_CODE=00, EVT_COUNT=0, OVERFLOW=0, DROP_CNT=0.
  - Pending entries are discarded.

## Timing
- All outputs are registered and update on the CLK1K rising edge.
- Push latency: a key pulse sampled at edge N into an empty FIFO gives EVT_VALID=1 with its code after edge N, so it is visible in cycle N+1.
- Pop: VALID && READY sampled at edge N advances the head. The next entry, or EVT_VALID=0 and EVT_CODE=00 if none remains, appears after edge N.
- Back-to-back pops at one per cycle are supported; a continuously ready consumer drains DEPTH entries in DEPTH cycles.
- While EVT_VALID=1 and EVT_READY=0, EVT_CODE holds stable.
- EVT_COUNT, OVERFLOW and DROP_CNT reflect the state after the same edge as the FIFO update.
- The consumer may hold EVT_READY high permanently. There is no combinational path from EVT_READY to any output.

## Test plan
- Reset, then one KEY2 pulse at cycle 5 with READY=0: EVT_VALID=1, EVT_CODE=10, EVT_COUNT=1 from cycle 6; outputs hold until READY; READY for one cycle then gives EVT_VALID=0, EVT_CODE=00, EVT_COUNT=0.
- Pulses KEY1, KEY3, KEY2, KEY1 on consecutive cycles with READY=0, then READY=1: codes 01, 11, 10, 01 are read in order on 4 consecutive cycles; EVT_COUNT reads 4, 3, 2, 1, 0.
- Fill to 4 with READY=0, then 3 more KEY1 pulses: contents unchanged, OVERFLOW=1, DROP_CNT=3; pulse OVF_CLR: OVERFLOW=0, DROP_CNT=0; FIFO still holds 4 entries.
- Full FIFO, KEY3 pulse with READY=1 in the same cycle: head popped, 11 appended, EVT_COUNT stays 4, no drop; the 11 emerges 4th in the drain order.
- KEY1, KEY2 and KEY3 all high in one cycle: exactly one entry of code 11, EVT_COUNT=1, DROP_CNT=0. Separately, with the FIFO full, a KEY1 pulse in the same cycle as OVF_CLR gives OVERFLOW=1, DROP_CNT=1.
- With 3 entries queued and EVT_VALID=1, assert RSTN=0 for 2 cycles mid-cycle: all outputs reach reset values asynchronously; after release, a single KEY1 pulse gives a single 01 entry and no stale data appears.
